// File: rtl/sccb_pkg.sv
// Shared SCCB master definitions: FSM encoding, per-quarter bus waveforms and frame lengths.
package sccb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StTxBit,
        StTxAck,
        StRxBit,
        StRxNa,
        StStop
    } sccb_state_e;

    // Bus levels per quarter; bit 0 is the first quarter of the phase.
    localparam logic [3:0] StartSda = 4'b0001;
    localparam logic [3:0] StartScl = 4'b0011;
    localparam logic [3:0] BitScl   = 4'b1100;
    localparam logic [3:0] StopSda  = 4'b1100;
    localparam logic [3:0] StopScl  = 4'b1110;

    localparam logic [1:0] SampleQtr = 2'd2;
    localparam logic [1:0] LastQtr   = 2'd3;

    localparam logic [7:0] WriteQtrs = 8'd116;
    localparam logic [7:0] ReadQtrs  = 8'd160;

    function automatic logic [7:0] txn_qtrs(input logic rw);
        return rw ? ReadQtrs : WriteQtrs;
    endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit strobe: one-cycle tick every QTR_DIV clocks while enabled, held cleared otherwise.
module sccb_tick_gen #(
    parameter int unsigned QTR_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] CntMax = 16'(QTR_DIV - 1);

    logic [15:0] cnt_q;

    assign tick = en && (cnt_q == CntMax);

    always_ff @(posedge clk) begin
        if (rst || !en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/sccb_master.sv
// SCCB master: 3-phase register write, or 2-phase write then 2-phase read, over open-drain SDA.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int unsigned QTR_DIV   = 125,
    parameter bit          CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] id,
    input  logic [7:0] rega,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    inout  wire        SDA,
    output logic       SCL
);

    sccb_state_e state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic        rd_phase_q, rd_phase_d;
    logic        rw_q, rw_d;
    logic [7:0]  id_q, id_d, rega_q, rega_d, wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]  sda_sync_q;
    logic        sda_in, sda_rel, tick;
    logic [7:0]  tx_byte;
    logic        unused_id0;

    assign unused_id0 = id_q[0];
    assign sda_in     = sda_sync_q[1];

    sccb_tick_gen #(
        .QTR_DIV(QTR_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (busy_q),
        .tick(tick)
    );

    // Address LSB is the R/W flag: write in the first frame, read in the repeated-start frame.
    always_comb begin
        case (byte_q)
            2'd0:    tx_byte = {id_q[7:1], rd_phase_q};
            2'd1:    tx_byte = rega_q;
            default: tx_byte = wdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        qcnt_d     = qcnt_q;
        rd_phase_d = rd_phase_q;
        rw_d       = rw_q;
        id_d       = id_q;
        rega_d     = rega_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        nack_d     = nack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StStart;
                    qtr_d      = '0;
                    bit_d      = 3'd7;
                    byte_d     = '0;
                    qcnt_d     = '0;
                    rd_phase_d = 1'b0;
                    rw_d       = rw;
                    id_d       = id;
                    rega_d     = rega;
                    wdata_d    = wdata;
                    nack_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    qtr_d  = qtr_q + 2'd1;
                    qcnt_d = qcnt_q + 8'd1;
                    if (qtr_q == SampleQtr) begin
                        if (state_q == StTxAck && CHECK_ACK && sda_in) begin
                            nack_d = 1'b1;
                        end
                        if (state_q == StRxBit) begin
                            rdata_d = {rdata_q[6:0], sda_in};
                        end
                    end
                    if (qtr_q == LastQtr) begin
                        unique case (state_q)
                            StStart: begin
                                state_d = StTxBit;
                                bit_d   = 3'd7;
                            end
                            StTxBit: begin
                                if (bit_q == 3'd0) state_d = StTxAck;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            StTxAck: begin
                                bit_d = 3'd7;
                                if (rd_phase_q) begin
                                    state_d = StRxBit;
                                end else if (byte_q == (rw_q ? 2'd1 : 2'd2)) begin
                                    state_d = StStop;
                                end else begin
                                    state_d = StTxBit;
                                    byte_d  = byte_q + 2'd1;
                                end
                            end
                            StRxBit: begin
                                if (bit_q == 3'd0) state_d = StRxNa;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            StRxNa: state_d = StStop;
                            default: begin
                                // Only the final STOP ends the transaction; a read's first STOP
                                // is followed by a repeated START for the read frame.
                                if (qcnt_q == txn_qtrs(rw_q) - 8'd1) begin
                                    state_d = StIdle;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d    = StStart;
                                    byte_d     = '0;
                                    rd_phase_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        SCL     = 1'b1;
        sda_rel = 1'b1;
        unique case (state_q)
            StIdle: begin
                SCL     = 1'b1;
                sda_rel = 1'b1;
            end
            StStart: begin
                SCL     = StartScl[qtr_q];
                sda_rel = StartSda[qtr_q];
            end
            StTxBit: begin
                SCL     = BitScl[qtr_q];
                sda_rel = tx_byte[bit_q];
            end
            StStop: begin
                SCL     = StopScl[qtr_q];
                sda_rel = StopSda[qtr_q];
            end
            default: begin
                SCL     = BitScl[qtr_q];
                sda_rel = 1'b1;
            end
        endcase
    end

    assign SDA = sda_rel ? 1'bz : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            qtr_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            qcnt_q     <= '0;
            rd_phase_q <= 1'b0;
            rw_q       <= 1'b0;
            id_q       <= '0;
            rega_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            qcnt_q     <= qcnt_d;
            rd_phase_q <= rd_phase_d;
            rw_q       <= rw_d;
            id_q       <= id_d;
            rega_q     <= rega_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sda_sync_q <= {sda_sync_q[0], SDA};
        end
    end

    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;

endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 Parameter QTR_DIV, default 125, meaning clk cycles per quarter-bit (125 = 100 kHz SCL at 50 MHz clk); legal range 2..65535.
REQ-002 Parameter CHECK_ACK, default 1, meaning 1 = record slave ACK bits into nack, 0 = ignore them (pure SCCB don't-care).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  request a transaction; sampled only while busy=0.
REQ-006 rw  in  1  0 = 3-phase write, 1 = 2-phase write followed by 2-phase read.
REQ-007 id  in  8  device write address; bit0 ignored; read phase uses {id[7:1],1}.
REQ-008 rega  in  8  register sub-address.
REQ-009 wdata  in  8  write value, used when rw=0.
REQ-010 rdata  out  8  read value, valid from done pulse until next accepted start.
REQ-011 busy  out  1  high from the cycle after start is accepted until done.
REQ-012 done  out  1  one-cycle pulse at transaction end.
REQ-013 nack  out  1  sticky per transaction; high if any checked ACK sampled 1.
REQ-014 SDA  inout  1  open-drain: drives 0 or Z only, never 1.
REQ-015 SCL  out  1  push-pull clock, 1 when idle.

Function
REQ-016 A quarter tick shall assert for one clk every QTR_DIV cycles while busy; the counter shall clear on start acceptance so the first quarter is exactly QTR_DIV cycles.
REQ-017 On start acceptance id, rega, wdata and rw shall be latched; later input changes shall have no effect until done.
REQ-018 A start while busy=0 shall be accepted, including in the done cycle; a start while busy=1 shall be ignored.
REQ-019 States: IDLE, START, TX_BIT, TX_ACK, RX_BIT, RX_NA, STOP; each non-IDLE state advances only on quarter ticks.
REQ-020 START (4 quarters): SDA/SCL = 1/1, 0/1, 0/0, 0/0.
REQ-021 Bit (4 quarters): q0 SCL=0 and SDA set; q1 SCL=0; q2 SCL=1; q3 SCL=1; SDA sampled at the end of q2. SDA shall never change while SCL=1 except in START and STOP.
REQ-022 Bytes are sent MSB first; a 3-bit bit counter counts 7 down to 0 and a 2-bit byte index selects id, rega or wdata.
REQ-023 TX_ACK: SDA released for one bit; when CHECK_ACK=1, a sampled 1 sets nack.
REQ-024 RX_BIT: SDA released; sampled bits shift into rdata MSB first. RX_NA: SDA released (NA=1).
REQ-025 STOP (4 quarters): SDA/SCL = 0/0, 0/1, 1/1, 1/1.
REQ-026 rw=0 sequence: START, id, rega, wdata (each byte followed by ACK), STOP. Total 116 quarters.
REQ-027 rw=1 sequence: START, id, rega, STOP, then START, {id[7:1],1}, RX byte, NA, STOP. Total 160 quarters.
REQ-028 A NACK shall not abort the transaction; the sequence completes and nack reports it.
REQ-029 done shall pulse in the clk following the last STOP quarter; busy shall fall in the same cycle.
REQ-030 nack shall clear on start acceptance; rdata shall hold its value between read transactions.

Reset
REQ-031 While rst=1: state=IDLE, SDA=Z, SCL=1, busy=0, done=0, nack=0, rdata=0, tick counter=0.
REQ-032 rst asserted mid-transaction shall release the bus on the next clk edge with no STOP generated and no done pulse.

Structure
REQ-033 Package sccb_pkg holds the state encoding, the 4-quarter phase constants and the transaction length constants (116 and 160).
REQ-034 The quarter-tick divider shall be a sub-module, sccb_tick_gen, parametrised by QTR_DIV, with ports clk, rst, en, tick.

Verification
REQ-035 QTR_DIV=4; write id=0x42, rega=0x12, wdata=0x80; slave ACKs -> decoded bytes 42/12/80, done at cycle 464 after acceptance, nack=0.
REQ-036 Read id=0x42, rega=0x0A; slave returns 0x76 -> second address byte 0x43, NA=1, rdata=0x76, done at cycle 640.
REQ-037 Slave NACKs rega, CHECK_ACK=1 -> full transaction still completes, nack=1; the same stimulus with CHECK_ACK=0 -> nack=0.
REQ-038 start pulsed mid-transaction with a changed wdata -> ignored; original data sent; back-to-back start in the done cycle is accepted.
REQ-039 rst asserted at quarter 50 -> SDA=Z and SCL=1 on the next edge, no done pulse; a new write afterwards is correct.
REQ-040 Protocol monitor on all tests: no SDA change while SCL=1 outside START/STOP; SDA never driven to 1.
